// File: rtl/pfb_dbg_pkg.sv
// Shared debug definitions for the PFB co-simulation deadlock monitors.
// Contents:
//   DBG_NUM_AXIS   - number of AXIS ports watched per dataflow process
//   DBG_BLK_CNT_W  - width of the saturating blocked-cycle statistic
//   axis_vec_t     - one bit per monitored AXIS port
//   lowest_set_idx - priority encoder: index of the lowest set bit (0 if none)
package pfb_dbg_pkg;

    localparam int DBG_NUM_AXIS  = 12;
    localparam int DBG_BLK_CNT_W = 16;

    typedef logic [DBG_NUM_AXIS-1:0] axis_vec_t;

    // Scans from the top down so the last hit is the lowest set bit.
    function automatic int lowest_set_idx(input axis_vec_t v);
        int idx;
        idx = 0;
        for (int i = DBG_NUM_AXIS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_stall_counter.sv
// Per-channel stall counter for one AXIS port.
// A consumer port (IS_INPUT=1) stalls when it is ready but nothing is offered;
// a producer port (IS_INPUT=0) stalls when it offers data that is not taken.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   enable        - 0 holds the counter at zero
//   tvalid/tready - handshake pair of the watched port
//   blocked       - counter sits at STALL_THRESH
//   just_blocked  - counter moves into STALL_THRESH on the coming edge
module axis_stall_counter #(
    parameter int CNT_W        = 8,
    parameter int STALL_THRESH = 16,
    parameter bit IS_INPUT     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic tvalid,
    input  logic tready,
    output logic blocked,
    output logic just_blocked
);

    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(STALL_THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = IS_INPUT ? (tready & ~tvalid) : (tvalid & ~tready);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable && stall) begin
            if (cnt != THRESH) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign blocked = (cnt == THRESH);

    // Transition pulse: lets the top capture only fresh blocks, so a channel
    // parked at threshold across a clear never re-triggers the capture.
    assign just_blocked = enable & stall & (cnt == THRESH_M1);

endmodule

// File: rtl/axis_block_detector.sv
// Per-channel AXI-Stream block detector feeding the per-process deadlock
// monitors. Each port gets a stall counter; the top ORs the block bits,
// captures the first blocking channel and counts cycles spent blocked.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   enable                - detection enable (0 zeroes all stall counters)
//   clear                 - clears the sticky capture and block_cycles
//   ch_tvalid, ch_tready  - handshake pairs of the monitored ports
//   axis_block_sigs       - per-channel blocked flags
//   any_block             - OR of axis_block_sigs
//   first_block_valid     - sticky: a first blocker has been captured
//   first_block_idx       - index of the first blocked channel
//   block_cycles          - saturating count of cycles with any_block=1
// NUM_CH must not exceed DBG_NUM_AXIS (width of the priority-encode vector).
module axis_block_detector
    import pfb_dbg_pkg::*;
#(
    parameter int                NUM_CH        = 12,
    parameter int                STALL_THRESH  = 16,
    parameter int                CNT_W         = 8,
    parameter logic [NUM_CH-1:0] IS_INPUT_MASK = 12'h0FF,
    parameter int                IDX_W         = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        ch_tvalid,
    input  logic [NUM_CH-1:0]        ch_tready,
    output logic [NUM_CH-1:0]        axis_block_sigs,
    output logic                     any_block,
    output logic                     first_block_valid,
    output logic [IDX_W-1:0]         first_block_idx,
    output logic [DBG_BLK_CNT_W-1:0] block_cycles
);

    logic [NUM_CH-1:0] blocked;
    logic [NUM_CH-1:0] just_blocked;
    axis_vec_t         just_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        axis_stall_counter #(
            .CNT_W        (CNT_W),
            .STALL_THRESH (STALL_THRESH),
            .IS_INPUT     (IS_INPUT_MASK[i])
        ) u_cnt (
            .clock        (clock),
            .reset        (reset),
            .enable       (enable),
            .tvalid       (ch_tvalid[i]),
            .tready       (ch_tready[i]),
            .blocked      (blocked[i]),
            .just_blocked (just_blocked[i])
        );
    end

    assign axis_block_sigs = blocked;
    assign any_block       = |blocked;

    always_comb begin
        just_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            just_vec[i] = just_blocked[i];
        end
    end

    // clear outranks both the capture and the statistic increment.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            first_block_valid <= 1'b0;
            first_block_idx   <= '0;
            block_cycles      <= '0;
        end else begin
            if (!first_block_valid && (|just_blocked)) begin
                first_block_valid <= 1'b1;
                first_block_idx   <= IDX_W'(lowest_set_idx(just_vec));
            end
            if (any_block && (block_cycles != '1)) begin
                block_cycles <= block_cycles + DBG_BLK_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_block_detector.sv
// Directed self-checking bench for axis_block_detector.
// dut0 uses the default configuration (threshold 16, mask 12'h0FF);
// dut1 uses STALL_THRESH=1 to reach block_cycles saturation quickly.
module tb_axis_block_detector;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [11:0] tv0, tr0, tv1, tr1;

    logic [11:0] sigs0, sigs1;
    logic        any0, any1;
    logic        fv0, fv1;
    logic [3:0]  fidx0, fidx1;
    logic [15:0] cyc0, cyc1;

    int total = 0;
    int bad   = 0;

    axis_block_detector u_dut0 (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .clear             (clear),
        .ch_tvalid         (tv0),
        .ch_tready         (tr0),
        .axis_block_sigs   (sigs0),
        .any_block         (any0),
        .first_block_valid (fv0),
        .first_block_idx   (fidx0),
        .block_cycles      (cyc0)
    );

    axis_block_detector #(.STALL_THRESH(1)) u_dut1 (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .clear             (clear),
        .ch_tvalid         (tv1),
        .ch_tready         (tr1),
        .axis_block_sigs   (sigs1),
        .any_block         (any1),
        .first_block_valid (fv1),
        .first_block_idx   (fidx1),
        .block_cycles      (cyc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Return every port to idle, let block bits drop, then pulse clear.
    task automatic idle_and_clear();
        tv0 = '0; tr0 = '0;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("idle_sigs", 32'(sigs0), 32'h0);
        check("idle_fv",   32'(fv0),   32'h0);
        check("idle_cyc",  32'(cyc0),  32'h0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0;
        tv0 = '0; tr0 = '0; tv1 = '0; tr1 = '0;
        tick(2);

        // Reset state
        check("rst_sigs", 32'(sigs0), 32'h0);
        check("rst_any",  32'(any0),  32'h0);
        check("rst_fv",   32'(fv0),   32'h0);
        check("rst_idx",  32'(fidx0), 32'h0);
        check("rst_cyc",  32'(cyc0),  32'h0);
        check("rst_cyc1", 32'(cyc1),  32'h0);
        reset = 1'b0;
        tick(1);

        // 1: consumer channel 0 starved
        tr0[0] = 1'b1;
        tick(15);
        check("t1_pre_sig", 32'(sigs0), 32'h0);
        check("t1_pre_fv",  32'(fv0),   32'h0);
        tick(1);
        check("t1_sig",  32'(sigs0), 32'h001);
        check("t1_any",  32'(any0),  32'h1);
        check("t1_fv",   32'(fv0),   32'h1);
        check("t1_idx",  32'(fidx0), 32'h0);
        check("t1_cyc0", 32'(cyc0),  32'h0);
        tick(4);
        check("t1_cyc4", 32'(cyc0),  32'h4);
        tr0[0] = 1'b0;
        tick(1);
        check("t1_rel_sig", 32'(sigs0), 32'h0);
        check("t1_rel_cyc", 32'(cyc0),  32'h5);
        tick(1);
        check("t1_hold_cyc", 32'(cyc0), 32'h5);
        check("t1_hold_fv",  32'(fv0),  32'h1);
        idle_and_clear();

        // 2: producer channel 9, handshake at 15 restarts the count
        tv0[9] = 1'b1;
        tick(15);
        check("t2_15", 32'(sigs0), 32'h0);
        tr0[9] = 1'b1;
        tick(1);
        check("t2_hs", 32'(sigs0), 32'h0);
        tr0[9] = 1'b0;
        tick(15);
        check("t2_re15", 32'(sigs0), 32'h0);
        check("t2_re15_fv", 32'(fv0), 32'h0);
        tick(1);
        check("t2_sig", 32'(sigs0), 32'h200);
        check("t2_idx", 32'(fidx0), 32'h9);
        check("t2_fv",  32'(fv0),   32'h1);
        idle_and_clear();

        // 3: channels 3 (consumer) and 10 (producer) together
        tr0[3]  = 1'b1;
        tv0[10] = 1'b1;
        tick(16);
        check("t3_sig", 32'(sigs0), 32'h408);
        check("t3_idx", 32'(fidx0), 32'h3);
        check("t3_fv",  32'(fv0),   32'h1);
        idle_and_clear();

        // 4: clear while ch5 stays blocked, then a fresh block re-captures
        tr0[5] = 1'b1;
        tick(16);
        check("t4_idx", 32'(fidx0), 32'h5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t4_clr_fv",  32'(fv0),   32'h0);
        check("t4_clr_cyc", 32'(cyc0),  32'h0);
        check("t4_clr_sig", 32'(sigs0), 32'h020);
        tick(3);
        check("t4_nocap_fv", 32'(fv0),  32'h0);
        check("t4_cyc3",     32'(cyc0), 32'h3);
        tr0[5] = 1'b0;
        tick(1);
        check("t4_rel_sig", 32'(sigs0), 32'h0);
        tr0[5] = 1'b1;
        tick(15);
        check("t4_re15_fv", 32'(fv0), 32'h0);
        tick(1);
        check("t4_re_fv",  32'(fv0),   32'h1);
        check("t4_re_idx", 32'(fidx0), 32'h5);
        idle_and_clear();

        // 5: reset mid-stall on ch2, then enable drop mid-block
        tr0[2] = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_rst_sig", 32'(sigs0), 32'h0);
        tick(15);
        check("t5_15", 32'(sigs0), 32'h0);
        tick(1);
        check("t5_sig", 32'(sigs0), 32'h004);
        check("t5_idx", 32'(fidx0), 32'h2);
        enable = 1'b0;
        tick(1);
        check("t5_en_sig", 32'(sigs0), 32'h0);
        check("t5_en_fv",  32'(fv0),   32'h1);
        enable = 1'b1;
        tick(15);
        check("t5_en15", 32'(sigs0), 32'h0);
        tick(1);
        check("t5_en_re", 32'(sigs0), 32'h004);
        check("t5_en_idx", 32'(fidx0), 32'h2);
        idle_and_clear();

        // 6: STALL_THRESH=1, block_cycles saturation
        tr1[0] = 1'b1;
        tick(1);
        check("t6_sig1", 32'(sigs1), 32'h001);
        check("t6_cyc0", 32'(cyc1),  32'h0);
        check("t6_idx",  32'(fidx1), 32'h0);
        tick(65534);
        check("t6_fffe", 32'(cyc1), 32'hFFFE);
        tick(1);
        check("t6_ffff", 32'(cyc1), 32'hFFFF);
        tick(4465);
        check("t6_sat", 32'(cyc1), 32'hFFFF);
        tr1[0] = 1'b0;
        tick(1);
        check("t6_rel_sig", 32'(sigs1), 32'h0);
        check("t6_rel_cyc", 32'(cyc1),  32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_block_detector.md
Name: axis_block_detector

Overview:
Produces the per-channel AXI-Stream block vector consumed by the per-process deadlock monitors in the PFB co-simulation harness.
- Watches the tvalid/tready pair of each AXIS port of a dataflow process.
- Counts consecutive stall cycles per port and asserts that port's block bit once a threshold is reached.
- Captures the first blocking channel and accumulates blocked-cycle statistics for the deadlock report.

Parameters:
NUM_CH, 12, number of monitored AXIS ports (matches axis_block_sigs width).
STALL_THRESH, 16, consecutive stall cycles before a channel is declared blocked; legal range 1..2**CNT_W-1.
CNT_W, 8, stall counter width.
IS_INPUT_MASK, 12'h0FF, bit i=1: process is the consumer on channel i; bit i=0: process is the producer.
IDX_W, 4, width of channel index; must be >= clog2(NUM_CH).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  detection enable; 0 forces all counters to 0
clear  in  1  clears sticky capture and statistics
ch_tvalid  in  NUM_CH  tvalid of each monitored port
ch_tready  in  NUM_CH  tready of each monitored port
axis_block_sigs  out  NUM_CH  per-channel blocked flag
any_block  out  1  OR of axis_block_sigs
first_block_valid  out  1  sticky; a first blocker has been captured
first_block_idx  out  IDX_W  index of the first blocked channel
block_cycles  out  16  saturating count of cycles with any_block=1

Behaviour:
- Reset: all counters 0; axis_block_sigs=0; any_block=0; first_block_valid=0; first_block_idx=0; block_cycles=0.
- Stall condition per channel i:
  - consumer (mask=1): tready=1 & tvalid=0 (starved).
  - producer (mask=0): tvalid=1 & tready=0 (back-pressured).
- Counter update per channel, per clock edge:
  - If enable=1 and stall: increment, saturating at STALL_THRESH.
  - Otherwise clear to 0. This covers a completed handshake (tvalid&tready), idle (both 0), and enable=0.
- axis_block_sigs[i] = (cnt[i] == STALL_THRESH), decoded from the registered count.
- Latency:
  - Stall held from cycle k: block bit is high from cycle k+STALL_THRESH.
  - The first non-stall cycle at k': block bit is low at cycle k'+1.
- STALL_THRESH=1: block bit follows stall delayed by one cycle.
- any_block = OR of axis_block_sigs. It is combinational from registers, so it has the same timing as the block bits.
- First-blocker capture:
  - When first_block_valid=0 and any counter transitions into STALL_THRESH on this edge, set first_block_valid=1.
  - first_block_idx = lowest index among the channels transitioning on that edge.
  - Further blocks do not update the capture.
- block_cycles: increments each cycle any_block=1; saturates at 16'hFFFF and never wraps.
- clear:
  - On the edge it is sampled, sets first_block_valid=0, first_block_idx=0, block_cycles=0.
  - Has priority over a simultaneous capture or increment.
  - Does not affect the stall counters. A channel still at threshold does NOT re-capture: capture fires only on a transition into threshold.
- Reset mid-stall: counters return to 0 and the full threshold must elapse again after reset deasserts.
- enable deasserted mid-stall: counters drop to 0 on the next edge; the sticky capture is retained.

Decomposition:
- Package pfb_dbg_pkg holds:
  - constants DBG_NUM_AXIS=12 and DBG_BLK_CNT_W=16;
  - typedef axis_vec_t (NUM_CH-bit logic vector);
  - function lowest_set_idx used for the priority encode.
- One sub-module, axis_stall_counter, instantiated NUM_CH times. It holds one channel: IS_INPUT bit, the counter, and outputs blocked and just_blocked (the transition pulse).
- Top level handles the priority capture, the OR reduction and block_cycles.

Test Plan:
1. Channel 0 (consumer), tready=1, tvalid=0 for 20 cycles from cycle 5 -> axis_block_sigs[0] rises at cycle 21; first_block_idx=0, valid=1; block_cycles=4 at cycle 25.
2. Channel 9 (producer), tvalid=1, tready=0 for 15 cycles, then tready=1 one cycle, then stall again -> no block bit; counter restarts; block at 16 cycles into the second stall.
3. Channels 3 and 10 start stalling on the same cycle -> both bits rise together; first_block_idx=3.
4. Channel 5 blocked, then clear pulsed while stall persists -> first_block_valid=0, block_cycles=0, no re-capture; release and re-stall of ch 5 for 16 cycles -> capture idx=5.
5. Channel 2 stalled 10 cycles, then reset for 1 cycle, then stall continues -> block at 16 cycles after reset deassertion, not before.
6. Force any_block high for 70000 cycles (STALL_THRESH=1) -> block_cycles saturates at 16'hFFFF, no wrap.
